// File: rtl/alu_mul_seq.sv
// alu_mul_seq: multi-cycle unsigned shift-and-add multiplier controller.
// Drives the shared combinational ALU (ADD / MVC) for WIDTH iterations
// and returns a 2*WIDTH product over a valid/ready handshake.
`ifndef WIDTH_WORD
`define WIDTH_WORD 8
`endif

module alu_mul_seq #(
  parameter  int WIDTH = `WIDTH_WORD,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_hi,
  output logic [WIDTH-1:0] resp_lo,
  output logic             resp_ovf,
  output logic             busy,
  output logic [2:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_carry
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_MVC = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   mq;
  logic [WIDTH-1:0]   mcand;
  logic [CNT_W-1:0]   cnt;
  logic               sum_c;
  logic [WIDTH-1:0]   part_hi;
  logic [WIDTH-1:0]   part_lo;
  logic               last_iter;

  // The W+1-bit partial sum {sum_c, alu_y} shifted right one place splits
  // into the new accumulator and the new low half (multiplier shifts out).
  assign part_hi   = {sum_c, alu_y[WIDTH-1:1]};
  assign part_lo   = {alu_y[0], mq[WIDTH-1:1]};
  assign last_iter = (cnt == CNT_W'(1));
  assign resp_ovf  = |resp_hi;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and ALU/handshake outputs; ALU is MVC/0/0 unless iterating.
  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    busy       = 1'b0;
    alu_op     = OP_MVC;
    alu_a      = '0;
    alu_b      = '0;
    sum_c      = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        busy  = 1'b1;
        alu_a = acc;
        alu_b = mcand;
        if (mq[0]) begin
          alu_op = OP_ADD;
          sum_c  = alu_carry;
        end else begin
          // MVC passes acc through; its carry-out is not meaningful.
          alu_op = OP_MVC;
          sum_c  = 1'b0;
        end
        if (last_iter) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        busy       = 1'b1;
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Operand load, per-iteration shift-and-add update, and result capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc     <= '0;
      mq      <= '0;
      mcand   <= '0;
      cnt     <= '0;
      resp_hi <= '0;
      resp_lo <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            mcand <= req_a;
            mq    <= req_b;
            acc   <= '0;
            cnt   <= CNT_W'(WIDTH);
          end
        end
        S_RUN: begin
          acc <= part_hi;
          mq  <= part_lo;
          cnt <= cnt - CNT_W'(1);
          if (last_iter) begin
            resp_hi <= part_hi;
            resp_lo <= part_lo;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: directed and random checks of alu_mul_seq (WIDTH=8)
// against an arithmetic reference; the ALU is modelled combinationally.
module tb_alu_mul_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic         resp_valid;
  logic         resp_ready;
  logic [W-1:0] resp_hi;
  logic [W-1:0] resp_lo;
  logic         resp_ovf;
  logic         busy;
  logic [2:0]   alu_op;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [W-1:0] alu_y;
  logic         alu_carry;
  logic         junk = 1'b0;

  int checks = 0;
  int errors = 0;

  // Operands presented on req_* while the controller is busy (must be ignored).
  logic         hold_en = 1'b0;
  logic [W-1:0] hold_a  = '0;
  logic [W-1:0] hold_b  = '0;

  alu_mul_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_hi    (resp_hi),
    .resp_lo    (resp_lo),
    .resp_ovf   (resp_ovf),
    .busy       (busy),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_y      (alu_y),
    .alu_carry  (alu_carry)
  );

  always #5 clk = ~clk;

  // Carry-out of a non-ADD op is garbage; make it wiggle.
  always @(posedge clk) junk <= ~junk;

  // Combinational ALU model: ADD gives sum and carry, MVC passes a through.
  always_comb begin
    if (alu_op == 3'b000) begin
      {alu_carry, alu_y} = {1'b0, alu_a} + {1'b0, alu_b};
    end else begin
      alu_y     = alu_a;
      alu_carry = junk;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full multiply: accept, W iteration cycles, DONE with 'hold' cycles
  // of backpressure, then the response handshake.
  task automatic do_mul(input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
    int prod;
    int part;
    prod = int'(a) * int'(b);
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    check("req_ready_before_accept", 32'(req_ready), 32'd1);
    step();
    if (hold_en) begin
      req_a = hold_a;
      req_b = hold_b;
    end else begin
      req_valid = 1'b0;
    end
    for (int i = 0; i < W; i++) begin
      part = (int'(a) * (int'(b) & ((1 << i) - 1))) >> i;
      check("run_busy", 32'(busy), 32'd1);
      check("run_req_ready", 32'(req_ready), 32'd0);
      check("run_resp_valid", 32'(resp_valid), 32'd0);
      check("run_alu_op", 32'(alu_op), b[i] ? 32'd0 : 32'd5);
      check("run_alu_a", 32'(alu_a), 32'(part));
      check("run_alu_b", 32'(alu_b), 32'(a));
      step();
    end
    for (int h = 0; h <= hold; h++) begin
      check("done_resp_valid", 32'(resp_valid), 32'd1);
      check("done_req_ready", 32'(req_ready), 32'd0);
      check("done_busy", 32'(busy), 32'd1);
      check("done_hi", 32'(resp_hi), 32'((prod >> W) & 'hFF));
      check("done_lo", 32'(resp_lo), 32'(prod & 'hFF));
      check("done_ovf", 32'(resp_ovf), (prod >> W) != 0 ? 32'd1 : 32'd0);
      check("done_alu_op", 32'(alu_op), 32'd5);
      if (h == hold) resp_ready = 1'b1;
      step();
    end
    resp_ready = 1'b0;
    check("idle_req_ready", 32'(req_ready), 32'd1);
    check("idle_resp_valid", 32'(resp_valid), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_hi_retained", 32'(resp_hi), 32'((prod >> W) & 'hFF));
    check("idle_lo_retained", 32'(resp_lo), 32'(prod & 'hFF));
  endtask

  task automatic check_reset_outputs();
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ovf", 32'(resp_ovf), 32'd0);
    check("rst_hi", 32'(resp_hi), 32'd0);
    check("rst_lo", 32'(resp_lo), 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd5);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_alu_b", 32'(alu_b), 32'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b0;
    step();
    step();
    check_reset_outputs();
    rst_n = 1'b1;
    step();
    check_reset_outputs();

    // Directed products and boundaries.
    do_mul(8'd3, 8'd5, 0);
    do_mul(8'hFF, 8'hFF, 0);
    do_mul(8'h00, 8'hA5, 0);
    do_mul(8'hA5, 8'h00, 1);
    do_mul(8'h80, 8'h18, 3);

    // Requests held during RUN/DONE must wait for the cycle after handshake.
    hold_en = 1'b1;
    hold_a  = 8'h2B;
    hold_b  = 8'hD7;
    do_mul(8'h11, 8'h0F, 0);
    hold_en = 1'b0;
    check("held_req_seen_idle", 32'(req_valid & req_ready), 32'd1);
    do_mul(8'h2B, 8'hD7, 0);

    // Reset in the 4th RUN cycle.
    req_valid = 1'b1;
    req_a     = 8'h5A;
    req_b     = 8'hC3;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("pre_reset_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_reset_outputs();
    do_mul(8'd7, 8'd9, 0);

    // Random pairs with random backpressure.
    for (int n = 0; n < 1000; n++) begin
      do_mul(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
